ram_responder: RTL and testbench
================================

# ram_responder

Data-memory responder for the sopc: sits on the slave end of the CPU memory-stage request interface and services word/halfword/byte loads and stores with byte-lane selects, optional wait states and range checking. The CPU issues word-aligned requests plus a 4-bit lane select and extracts or sign-extends bytes itself. This block merges store lanes into the stored word and returns whole words.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; capacity is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 0: extra cycles inserted before each response. Legal range 0..7.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low; 0 asserts reset.
- `request_valid`  in  1: request present.
- `request_ready`  out  1: responder can accept this cycle.
- `request_write`  in  1: 1 = store, 0 = load.
- `request_address`  in  32: byte address; bits [1:0] are ignored; word index = `[ADDR_WIDTH+1:2]`.
- `request_select`  in  4: byte lanes; bit i selects data[8i+7:8i]. Used by stores; ignored by loads.
- `request_data`  in  32: store data, already lane-aligned by the CPU.
- `response_valid`  out  1: one-cycle pulse, one per accepted request.
- `response_data`  out  32: word at the address after the access.
- `response_error`  out  1: accepted address was out of range; qualified by `response_valid`.

## Operation
- FSM states are IDLE, WAIT and RESPOND.
- Accept: a request is accepted when `request_valid && request_ready`. `request_ready` = (state==IDLE) || (state==RESPOND).
- On the accept edge:
  - Store: lanes with select=1 are written with the `request_data` lanes. Other lanes keep their old value. select=0000 leaves memory unchanged but still gets a response.
  - Load: the word is captured into the response register.
  - Store: the merged word is captured into the response register.
- Out-of-range address: `request_address[31:ADDR_WIDTH+2]` != 0. The store is dropped, the response word is 0, and `response_error` = 1.
- Transitions:
  - IDLE → accept → WAIT if WAIT_CYCLES>0, else RESPOND.
  - WAIT counts WAIT_CYCLES cycles, then goes to RESPOND.
  - RESPOND → accept → WAIT or RESPOND (back-to-back accept). With no accept, RESPOND → IDLE.
- No response backpressure: the requester must take the response during the `response_valid` cycle.
- Memory contents are not reset and power up X. Only the FSM, wait counter and response registers are reset.

## Timing
- Reset values: `request_ready`=1, `response_valid`=0, `response_data`=0, `response_error`=0, state IDLE, counter 0.
- Latency: for an accept at edge N, `response_valid`=1 in the cycle following edge N+1+WAIT_CYCLES, for exactly one cycle.
- Throughput:
  - WAIT_CYCLES=0: one access per cycle, sustained.
  - Otherwise: one access per WAIT_CYCLES+1 cycles.
- Read-after-write: a store commits at its accept edge. A load accepted on any later edge returns the merged word. There is no hazard window.
- `response_data` and `response_error` hold their value outside `response_valid` cycles. They change only on a response-register load.
- Reset asserted mid-operation: the pending response is discarded and no `response_valid` pulse occurs. A store already accepted stays committed. After deassertion, the first accept is possible on the first rising edge.
- `request_valid` while `request_ready`=0 has no effect. The requester holds its request until accepted.

## Structure
- Shared package `ram_defines` holds:
  - state encoding: IDLE, WAIT, RESPOND as 2-bit constants
  - SELECT_WIDTH = 4
  - the word and byte width constants
- One sub-module, `ram_array`: the storage array with per-lane write enable. It is instantiated as `array`, with memory `storage` indexed by word, so that benches can reach `ram_responder.array.storage` for `$readmemh` and dumps.
- The top level holds the FSM, the wait counter, the range check and the response registers.

## Test plan
- Reset, then IDLE: drive `reset`=0 mid-WAIT, with WAIT_CYCLES=3 and a load accepted → no `response_valid` ever. After release, `request_ready`=1 and the outputs are 0.
- Byte stores: word 0 preloaded 0x00000000; store select 0010 data 0x0000FF00, then store select 0001 data 0x000000EE → responses 0x0000FF00, then 0x0000FFEE. A load of word 0 returns 0x0000FFEE.
- Halfword store and back-to-back, WAIT_CYCLES=0: store select 1100 data 0x44550000 to word 1, then a load of word 1 accepted on the next cycle → `response_valid` on consecutive cycles; the load returns 0x44550000.
- Null store: select 0000 data 0xFFFFFFFF to word 2, holding 0x12345678 → response 0x12345678, memory unchanged.
- Wait states, WAIT_CYCLES=2: load accepted at edge N → `request_ready`=0 for 2 cycles, and `response_valid` for exactly 1 cycle after edge N+3.
- Range error, ADDR_WIDTH=10: store to 0x00001000 → `response_error`=1 and `response_data`=0. Word 0 is unchanged.

Source files
------------

// File: rtl/ram_defines.sv
// ============================================================================
// Module   : ram_defines
// Purpose  : Shared types and constants for the ram_responder data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_defines;

  localparam int WORD_WIDTH   = 32;
  localparam int BYTE_WIDTH   = 8;
  localparam int SELECT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Lanes with a select bit take the new data; the rest keep the old word.
  function automatic logic [WORD_WIDTH-1:0] merge_lanes(
    input logic [WORD_WIDTH-1:0]   old_word,
    input logic [WORD_WIDTH-1:0]   new_word,
    input logic [SELECT_WIDTH-1:0] select
  );
    logic [WORD_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < SELECT_WIDTH; i++) begin
      if (select[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_array.sv
// ============================================================================
// Module   : ram_array
// Purpose  : Word-indexed storage with per-byte-lane write enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_array
  import ram_defines::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clock,
  input  logic                    write_enable,
  input  logic [SELECT_WIDTH-1:0] select,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [WORD_WIDTH-1:0]   write_data,
  output logic [WORD_WIDTH-1:0]   read_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] storage [0:DEPTH-1];

  always_ff @(posedge clock) begin
    if (write_enable) begin
      for (int i = 0; i < SELECT_WIDTH; i++) begin
        if (select[i]) storage[address][i*BYTE_WIDTH +: BYTE_WIDTH] <= write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign read_data = storage[address];

endmodule

`default_nettype wire

// File: rtl/ram_responder.sv
// ============================================================================
// Module   : ram_responder
// Purpose  : Data-memory slave for the CPU memory stage: lane-merged stores,
//            whole-word loads, optional wait states and range checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_responder
  import ram_defines::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    request_valid,
  output logic                    request_ready,
  input  logic                    request_write,
  input  logic [31:0]             request_address,
  input  logic [SELECT_WIDTH-1:0] request_select,
  input  logic [WORD_WIDTH-1:0]   request_data,
  output logic                    response_valid,
  output logic [WORD_WIDTH-1:0]   response_data,
  output logic                    response_error
);

  localparam logic [2:0] c_wait_last = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam state_t     c_after_accept = (WAIT_CYCLES > 0) ? WAIT : RESPOND;

  state_t                r_state;
  logic [2:0]            r_count;
  logic [WORD_WIDTH-1:0] r_pend_data;
  logic                  r_pend_error;

  logic                  w_accept;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_index;
  logic [WORD_WIDTH-1:0] w_old_word;
  logic [WORD_WIDTH-1:0] w_merged;
  logic                  w_unused;

  assign request_ready = (r_state == IDLE) || (r_state == RESPOND);
  assign w_accept      = request_valid && request_ready;
  assign w_in_range    = (request_address[31:ADDR_WIDTH+2] == '0);
  assign w_index       = request_address[ADDR_WIDTH+1:2];
  assign w_merged      = merge_lanes(w_old_word, request_data, request_select);
  assign w_unused      = ^request_address[1:0];

  ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) array (
    .clock        (clock),
    .write_enable (w_accept && request_write && w_in_range),
    .select       (request_select),
    .address      (w_index),
    .write_data   (request_data),
    .read_data    (w_old_word)
  );

  // The pending register decouples capture (accept edge) from delivery, so a
  // back-to-back accept cannot overwrite a response that is still being shown.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_pend_data    <= '0;
      r_pend_error   <= 1'b0;
      response_valid <= 1'b0;
      response_data  <= '0;
      response_error <= 1'b0;
    end else begin
      response_valid <= (r_state == RESPOND);
      if (r_state == RESPOND) begin
        response_data  <= r_pend_data;
        response_error <= r_pend_error;
      end

      case (r_state)
        IDLE, RESPOND: begin
          if (w_accept) begin
            r_state      <= c_after_accept;
            r_count      <= '0;
            r_pend_error <= !w_in_range;
            if (!w_in_range)        r_pend_data <= '0;
            else if (request_write) r_pend_data <= w_merged;
            else                    r_pend_data <= w_old_word;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (r_count == c_wait_last) r_state <= RESPOND;
          else                        r_count <= r_count + 3'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
// ============================================================================
// Module   : tb_ram_responder
// Purpose  : Self-checking bench for ram_responder with a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_responder;

  localparam int WB = 2;
  localparam int WC = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        a_valid, a_write, a_ready, a_rvalid, a_rerror;
  logic [31:0] a_addr, a_data, a_rdata;
  logic [3:0]  a_sel;

  logic        bc_valid, bc_write;
  logic [31:0] bc_addr, bc_data;
  logic [3:0]  bc_sel;
  logic        b_ready, b_rvalid, b_rerror, c_ready, c_rvalid, c_rerror;
  logic [31:0] b_rdata, c_rdata;

  ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_a (
    .clock(clock), .reset(reset), .request_valid(a_valid), .request_ready(a_ready),
    .request_write(a_write), .request_address(a_addr), .request_select(a_sel),
    .request_data(a_data), .response_valid(a_rvalid), .response_data(a_rdata),
    .response_error(a_rerror));

  ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WB)) dut_b (
    .clock(clock), .reset(reset), .request_valid(bc_valid), .request_ready(b_ready),
    .request_write(bc_write), .request_address(bc_addr), .request_select(bc_sel),
    .request_data(bc_data), .response_valid(b_rvalid), .response_data(b_rdata),
    .response_error(b_rerror));

  ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WC)) dut_c (
    .clock(clock), .reset(reset), .request_valid(bc_valid), .request_ready(c_ready),
    .request_write(bc_write), .request_address(bc_addr), .request_select(bc_sel),
    .request_data(bc_data), .response_valid(c_rvalid), .response_data(c_rdata),
    .response_error(c_rerror));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [0:1023];
  logic [31:0] exp_data_q[$];
  logic        exp_err_q[$];
  logic [31:0] last_data = 32'h0;
  logic        last_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One cycle on the zero-wait responder: the response to the previous
  // cycle's accept must appear now; this cycle's accept updates the model.
  task automatic a_step(input logic v, input logic w, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] data);
    logic [31:0] old_w, e;
    logic        err, due;
    int          idx;
    @(negedge clock);
    a_valid = v; a_write = w; a_addr = addr; a_sel = sel; a_data = data;
    due = (exp_data_q.size() > 0);
    @(posedge clock); #1;
    chk("a_ready", a_ready, 32'd1);
    chk("a_valid", a_rvalid, due);
    if (due) begin
      last_data = exp_data_q.pop_front();
      last_err  = exp_err_q.pop_front();
    end
    chk("a_data", a_rdata, last_data);
    chk("a_error", a_rerror, last_err);
    if (v) begin
      idx = int'(addr[11:2]);
      if (addr[31:12] != 0) begin
        e = 32'h0; err = 1'b1;
      end else begin
        old_w = model[idx];
        e = old_w;
        if (w) begin
          for (int i = 0; i < 4; i++) if (sel[i]) e[8*i +: 8] = data[8*i +: 8];
          model[idx] = e;
        end
        err = 1'b0;
      end
      exp_data_q.push_back(e);
      exp_err_q.push_back(err);
    end
  endtask

  // Single full-word access to the two wait-state responders, checking the
  // ready/valid timeline against each one's wait count.
  task automatic bc_access(input logic w, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clock);
    bc_valid = 1'b1; bc_write = w; bc_addr = addr; bc_sel = 4'hF; bc_data = exp;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      if (k == 0) bc_valid = 1'b0;
      chk("b_ready", b_ready, (k >= WB) ? 32'd1 : 32'd0);
      chk("b_valid", b_rvalid, (k == WB + 1) ? 32'd1 : 32'd0);
      if (k == WB + 1) chk("b_data", b_rdata, exp);
      chk("c_ready", c_ready, (k >= WC) ? 32'd1 : 32'd0);
      chk("c_valid", c_rvalid, (k == WC + 1) ? 32'd1 : 32'd0);
      if (k == WC + 1) chk("c_data", c_rdata, exp);
    end
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b0;
    a_valid = 0; a_write = 0; a_addr = 0; a_sel = 0; a_data = 0;
    bc_valid = 0; bc_write = 0; bc_addr = 0; bc_sel = 0; bc_data = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_a_ready", a_ready, 32'd1);  chk("rst_a_valid", a_rvalid, 32'd0);
    chk("rst_a_data", a_rdata, 32'd0);   chk("rst_a_error", a_rerror, 32'd0);
    chk("rst_b_ready", b_ready, 32'd1);  chk("rst_b_valid", b_rvalid, 32'd0);
    chk("rst_b_data", b_rdata, 32'd0);   chk("rst_b_error", b_rerror, 32'd0);
    chk("rst_c_ready", c_ready, 32'd1);  chk("rst_c_valid", c_rvalid, 32'd0);
    chk("rst_c_data", c_rdata, 32'd0);   chk("rst_c_error", c_rerror, 32'd0);
    @(negedge clock); reset = 1'b1;

    // Reset mid-WAIT discards the pending load response.
    @(negedge clock);
    bc_valid = 1'b1; bc_write = 1'b0; bc_addr = 32'h4; bc_sel = 4'hF;
    @(posedge clock); #1;
    bc_valid = 1'b0;
    chk("midrst_c_ready_wait", c_ready, 32'd0);
    @(posedge clock); #1;
    chk("midrst_c_ready_wait2", c_ready, 32'd0);
    @(negedge clock); reset = 1'b0;
    #1;
    chk("inrst_c_ready", c_ready, 32'd1);
    chk("inrst_c_valid", c_rvalid, 32'd0);
    repeat (2) begin
      @(posedge clock); #1;
      chk("inrst_b_valid", b_rvalid, 32'd0);
      chk("inrst_c_valid", c_rvalid, 32'd0);
    end
    @(negedge clock); reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      chk("postrst_b_valid", b_rvalid, 32'd0);
      chk("postrst_c_valid", c_rvalid, 32'd0);
      chk("postrst_c_ready", c_ready, 32'd1);
      chk("postrst_c_data", c_rdata, 32'd0);
      chk("postrst_c_error", c_rerror, 32'd0);
    end

    // Wait-state timeline: store then load the same word.
    r = $urandom;
    bc_access(1'b1, 32'hC, r);
    bc_access(1'b0, 32'hC, r);

    // Preload words 0..15 of the zero-wait responder through the port.
    for (int w = 0; w < 16; w++) begin
      r = (w == 0 || w == 1) ? 32'h0 : (w == 2) ? 32'h12345678 : $urandom;
      a_step(1, 1, 32'(w * 4), 4'hF, r);
    end

    a_step(1, 1, 32'h0, 4'b0010, 32'h0000FF00);
    a_step(1, 1, 32'h0, 4'b0001, 32'h000000EE);
    chk("byte_store1", a_rdata, 32'h0000FF00);
    a_step(1, 0, 32'h0, 4'b0000, 32'h0);
    chk("byte_store2", a_rdata, 32'h0000FFEE);
    a_step(0, 0, 32'h0, 4'b0000, 32'h0);
    chk("byte_load", a_rdata, 32'h0000FFEE);

    a_step(1, 1, 32'h4, 4'b1100, 32'h44550000);
    a_step(1, 0, 32'h4, 4'b0000, 32'h0);
    chk("hw_store", a_rdata, 32'h44550000);
    a_step(0, 0, 32'h0, 4'b0000, 32'h0);
    chk("hw_load_b2b_valid", a_rvalid, 32'd1);
    chk("hw_load", a_rdata, 32'h44550000);

    a_step(1, 1, 32'h8, 4'b0000, 32'hFFFFFFFF);
    a_step(1, 0, 32'h8, 4'b0000, 32'h0);
    chk("null_store", a_rdata, 32'h12345678);
    a_step(0, 0, 32'h0, 4'b0000, 32'h0);
    chk("null_load", a_rdata, 32'h12345678);

    a_step(1, 1, 32'h00001000, 4'hF, 32'hDEADBEEF);
    a_step(1, 0, 32'h0, 4'b0000, 32'h0);
    chk("range_data", a_rdata, 32'h0);
    chk("range_error", a_rerror, 32'd1);
    a_step(0, 0, 32'h0, 4'b0000, 32'h0);
    chk("range_word0", a_rdata, 32'h0000FFEE);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] addr;
      if ($urandom_range(15) == 0) addr = $urandom | 32'h00001000;
      else addr = {26'h0, 4'($urandom_range(15)), 2'($urandom)};
      a_step(($urandom_range(3) != 0), 1'($urandom), addr, 4'($urandom), $urandom);
    end
    repeat (2) a_step(0, 0, 32'h0, 4'b0000, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
